vec_mem_unit: RTL and testbench

- Memory-side engine for the vector load/store instructions (VLD = 4'b0100, VST = 4'b0101).
- The ALU supplies a 16-bit effective address. This block serialises the whole 256-bit vector transfer into 16 single-element accesses on the 16-bit data memory port.
- VST: moves a vector register to memory, one element at a time. VLD: gathers 16 memory words back into one 256-bit vector.
- Sits between the execute stage and data memory. Stalls the pipeline via busy.

---
 rtl/vmem_pkg.sv | 18 +
 rtl/vmem_addr_gen.sv | 35 +++
 rtl/vec_mem_unit.sv | 138 +++++++++++++
 tb/tb_vec_mem_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared opcodes, default geometry and FSM encoding for the vector memory unit.
package vmem_pkg;

    localparam logic [3:0] VLD = 4'b0100;
    localparam logic [3:0] VST = 4'b0101;

    localparam int unsigned ELEM_W_DEF   = 16;
    localparam int unsigned NUM_ELEM_DEF = 16;
    localparam int unsigned ADDR_W_DEF   = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StXfer  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } vmem_state_e;

endpackage

// File: rtl/vmem_addr_gen.sv
// Element counter and per-element address adder; addresses wrap modulo 2^ADDR_W.
module vmem_addr_gen
    import vmem_pkg::*;
#(
    parameter int unsigned NUM_ELEM = NUM_ELEM_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    localparam int unsigned CNT_W   = $clog2(NUM_ELEM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base,
    output logic [CNT_W-1:0]  cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              last
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt      = cnt_q;
    assign mem_addr = base + ADDR_W'(cnt_q);
    assign last     = (cnt_q == CNT_W'(NUM_ELEM - 1));

endmodule

// File: rtl/vec_mem_unit.sv
// Serialises VLD/VST vector transfers into single-element memory accesses.
// Optional range check (no wrap, err pulse) enabled by VMEM_BOUNDS_CHECK_EN.
module vec_mem_unit
    import vmem_pkg::*;
#(
    parameter int unsigned ELEM_W   = ELEM_W_DEF,
    parameter int unsigned NUM_ELEM = NUM_ELEM_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [3:0]                 opcode,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ELEM_W*NUM_ELEM-1:0] wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [ELEM_W*NUM_ELEM-1:0] rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_re,
    output logic                       mem_we,
    output logic [ELEM_W-1:0]          mem_wdata,
    input  logic [ELEM_W-1:0]          mem_rdata
);

    localparam int unsigned CNT_W = $clog2(NUM_ELEM);

    vmem_state_e               state_q;
    logic [ADDR_W-1:0]         base_q;
    logic [ELEM_W*NUM_ELEM-1:0] wdata_q;
    logic [ELEM_W*NUM_ELEM-1:0] rdata_q;
    logic                      is_store_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      err_q;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cap_idx;
    logic [ADDR_W-1:0] gen_addr;
    logic              last;
    logic              accept;
    logic              capture;
    logic              in_xfer;
    logic              oob;

    assign accept  = (state_q == StIdle) && start && ((opcode == VLD) || (opcode == VST));
    assign in_xfer = (state_q == StXfer);

`ifdef VMEM_BOUNDS_CHECK_EN
    assign oob = ({1'b0, base_addr} + (ADDR_W + 1)'(NUM_ELEM - 1)) > {1'b0, {ADDR_W{1'b1}}};
`else
    assign oob = 1'b0;
`endif

    vmem_addr_gen #(
        .NUM_ELEM (NUM_ELEM),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .enable   (in_xfer),
        .base     (base_q),
        .cnt      (cnt),
        .mem_addr (gen_addr),
        .last     (last)
    );

    // Read data lags the strobe by one cycle; after the final read the counter has wrapped
    // to 0, so cnt-1 addresses element NUM_ELEM-1 during the drain cycle.
    assign capture = !is_store_q && ((in_xfer && (cnt != '0)) || (state_q == StDrain));
    assign cap_idx = cnt - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            base_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            is_store_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (capture) begin
                rdata_q[cap_idx*ELEM_W +: ELEM_W] <= mem_rdata;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        base_q     <= base_addr;
                        wdata_q    <= wdata;
                        is_store_q <= (opcode == VST);
                        busy_q     <= 1'b1;
                        if (oob) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= StXfer;
                        end
                    end
                end
                StXfer: begin
                    if (last) begin
                        if (is_store_q) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_we    = in_xfer && is_store_q;
    assign mem_re    = in_xfer && !is_store_q;
    assign mem_addr  = in_xfer ? gen_addr : '0;
    assign mem_wdata = mem_we ? wdata_q[cnt*ELEM_W +: ELEM_W] : '0;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed self-checking bench for vec_mem_unit with a 1-cycle-latency memory model.
module tb_vec_mem_unit;

    localparam logic [3:0] OP_VLD = 4'b0100;
    localparam logic [3:0] OP_VST = 4'b0101;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   opcode;
    logic [15:0]  base_addr;
    logic [255:0] wdata;
    logic         busy, done, err;
    logic [255:0] rdata;
    logic [15:0]  mem_addr;
    logic         mem_re, mem_we;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;

    vec_mem_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .base_addr (base_addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Memory model: xor_mode returns addr^0xA5A5, otherwise a RAM.
    logic        xor_mode = 1'b1;
    logic [15:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= xor_mode ? (mem_addr ^ 16'hA5A5) : ram[mem_addr];
    end

    // Strobe monitor, sampled mid-cycle.
    int          cyc = 0;
    int          wr_n = 0, re_n = 0, both_n = 0;
    logic [15:0] wr_addr [0:1023];
    logic [15:0] wr_data [0:1023];
    int          wr_cyc  [0:1023];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_n < 1024) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n = wr_n + 1;
        end
        if (mem_re) re_n = re_n + 1;
        if (mem_re && mem_we) both_n = both_n + 1;
    end

    logic [255:0] exp_rdata;

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic pulse_start(input logic [3:0] op, input logic [15:0] base,
                               input logic [255:0] wd);
        start = 1'b1; opcode = op; base_addr = base; wdata = wd;
        @(negedge clk);
        start = 1'b0; opcode = 4'b0000;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; opcode = '0; base_addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        n_total++; if ({busy, done, err, mem_re, mem_we} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mem_re, mem_we});
            else n_pass++;
        n_total++; if ({mem_addr, mem_wdata} !== 32'h0)
            $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata});
            else n_pass++;
        n_total++; if (rdata !== 256'h0) $display("FAIL reset_rdata: got %h want 0", rdata);
            else n_pass++;
        rst_n = 1'b1;
        exp_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_store;
        int w0, r0, lat;
        logic [255:0] wd;
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'h1000 + 16'(i);
        w0 = wr_n; r0 = re_n;
        pulse_start(OP_VST, 16'h0100, wd);
        wait_done(lat);
        n_total++; if (lat !== 17) $display("FAIL st_latency: got %0d want 17", lat); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL st_err: got %b want 0", err); else n_pass++;
        n_total++; if (wr_n - w0 !== 16) $display("FAIL st_wcount: got %0d want 16", wr_n - w0);
            else n_pass++;
        n_total++; if (re_n - r0 !== 0) $display("FAIL st_rcount: got %0d want 0", re_n - r0);
            else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if ({wr_addr[w0+i], wr_data[w0+i]} !== {16'h0100 + 16'(i), 16'h1000 + 16'(i)})
                $display("FAIL st_elem%0d: got addr %h data %h want %h %h", i, wr_addr[w0+i],
                         wr_data[w0+i], 16'h0100 + 16'(i), 16'h1000 + 16'(i));
            else n_pass++;
        end
        n_total++; if (wr_cyc[w0+15] - wr_cyc[w0] !== 15)
            $display("FAIL st_contig: got span %0d want 15", wr_cyc[w0+15] - wr_cyc[w0]);
            else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL st_busy_after: got %b want 0", busy);
            else n_pass++;
        n_total++; if (rdata !== exp_rdata) $display("FAIL st_rdata_kept: got %h want %h",
            rdata, exp_rdata); else n_pass++;
    endtask

    task automatic run_xor_load(input string tag, input logic [15:0] base);
        int w0, r0, lat;
        xor_mode = 1'b1;
        w0 = wr_n; r0 = re_n;
        pulse_start(OP_VLD, base, 256'h0);
        wait_done(lat);
        for (int i = 0; i < 16; i++) exp_rdata[16*i +: 16] = (base + 16'(i)) ^ 16'hA5A5;
        n_total++; if (lat !== 18) $display("FAIL %s_latency: got %0d want 18", tag, lat);
            else n_pass++;
        n_total++; if (rdata !== exp_rdata) $display("FAIL %s_rdata: got %h want %h", tag,
            rdata, exp_rdata); else n_pass++;
        n_total++; if (wr_n - w0 !== 0) $display("FAIL %s_wcount: got %0d want 0", tag,
            wr_n - w0); else n_pass++;
        n_total++; if (re_n - r0 !== 16) $display("FAIL %s_rcount: got %0d want 16", tag,
            re_n - r0); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_load;
        run_xor_load("ld", 16'h0200);
    endtask

    task automatic test_wrap;
        int w0, r0, lat;
        logic [255:0] wd;
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'h2000 + 16'(i);
        w0 = wr_n; r0 = re_n;
        pulse_start(OP_VST, 16'hFFF8, wd);
        wait_done(lat);
`ifdef VMEM_BOUNDS_CHECK_EN
        n_total++; if (lat !== 1) $display("FAIL wr_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL wr_err: got %b want 1", err); else n_pass++;
        n_total++; if (wr_n - w0 + re_n - r0 !== 0) $display("FAIL wr_strobes: got %0d want 0",
            wr_n - w0 + re_n - r0); else n_pass++;
        n_total++; if (rdata !== exp_rdata) $display("FAIL wr_rdata: got %h want %h", rdata,
            exp_rdata); else n_pass++;
        @(negedge clk);
        n_total++; if ({busy, err} !== 2'b00) $display("FAIL wr_after: got %b want 00",
            {busy, err}); else n_pass++;
`else
        n_total++; if (lat !== 17) $display("FAIL wr_latency: got %0d want 17", lat); else n_pass++;
        n_total++; if (wr_n - w0 !== 16) $display("FAIL wr_wcount: got %0d want 16", wr_n - w0);
            else n_pass++;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] ea;
            ea = 16'hFFF8 + 16'(i);
            n_total++;
            if (wr_addr[w0+i] !== ea)
                $display("FAIL wr_addr%0d: got %h want %h", i, wr_addr[w0+i], ea);
            else n_pass++;
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_ignored;
        int w0, r0, lat, bsy;
        logic [255:0] wd;
        logic [3:0] bad_ops [2];
        bad_ops[0] = 4'b0000; bad_ops[1] = 4'b0110;
        for (int k = 0; k < 2; k++) begin
            w0 = wr_n; r0 = re_n; bsy = 0;
            pulse_start(bad_ops[k], 16'h0100, {256{1'b1}});
            repeat (5) begin
                if (busy !== 1'b0) bsy++;
                @(negedge clk);
            end
            n_total++; if (bsy !== 0 || wr_n - w0 + re_n - r0 !== 0)
                $display("FAIL ign_op%0d: got busy_cycles %0d strobes %0d want 0 0", k, bsy,
                         wr_n - w0 + re_n - r0);
                else n_pass++;
        end
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'h3000 + 16'(i);
        w0 = wr_n;
        pulse_start(OP_VST, 16'h0600, wd);
        repeat (4) @(negedge clk);
        pulse_start(OP_VST, 16'h0700, {256{1'b1}});
        wait_done(lat);
        n_total++; if (lat !== 12) $display("FAIL ign_mid_latency: got %0d want 12", lat);
            else n_pass++;
        pulse_start(OP_VST, 16'h0800, {256{1'b1}});
        bsy = 0;
        repeat (20) begin
            if (busy !== 1'b0) bsy++;
            @(negedge clk);
        end
        n_total++; if (bsy !== 0) $display("FAIL ign_done_busy: got %0d busy cycles want 0", bsy);
            else n_pass++;
        n_total++; if (wr_n - w0 !== 16) $display("FAIL ign_wcount: got %0d want 16", wr_n - w0);
            else n_pass++;
        n_total++; if (wr_addr[w0+15] !== 16'h060F)
            $display("FAIL ign_last_addr: got %h want 060f", wr_addr[w0+15]); else n_pass++;
    endtask

    task automatic test_reset_mid_load;
        int r0, found;
        xor_mode = 1'b1;
        found = 0;
        pulse_start(OP_VLD, 16'h0400, 256'h0);
        for (int c = 0; c < 30; c++) begin
            if (mem_re === 1'b1 && mem_addr === 16'h0407) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_total++; if (found !== 1) $display("FAIL rst_reach_cnt7: got %0d want 1", found);
            else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_total++; if ({busy, done, err, mem_re, mem_we} !== 5'b0)
            $display("FAIL rst_mid_ctrl: got %b want 00000", {busy, done, err, mem_re, mem_we});
            else n_pass++;
        n_total++; if ({mem_addr, mem_wdata} !== 32'h0)
            $display("FAIL rst_mid_mem: got %h want 0", {mem_addr, mem_wdata}); else n_pass++;
        n_total++; if (rdata !== 256'h0) $display("FAIL rst_mid_rdata: got %h want 0", rdata);
            else n_pass++;
        rst_n = 1'b1;
        exp_rdata = '0;
        r0 = re_n;
        repeat (3) @(negedge clk);
        n_total++; if (re_n - r0 !== 0 || busy !== 1'b0)
            $display("FAIL rst_mid_quiet: got reads %0d busy %b want 0 0", re_n - r0, busy);
            else n_pass++;
        run_xor_load("rst_ld", 16'h0500);
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [255:0] wd;
        xor_mode = 1'b0;
        for (int i = 0; i < 16; i++) wd[16*i +: 16] = 16'(i * 16'h0F1D + 16'h3C5A);
        pulse_start(OP_VST, 16'h0300, wd);
        wait_done(lat);
        n_total++; if (lat !== 17) $display("FAIL b2b_st_latency: got %0d want 17", lat);
            else n_pass++;
        @(negedge clk);
        pulse_start(OP_VLD, 16'h0300, 256'h0);
        n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy %b want 1", busy);
            else n_pass++;
        wait_done(lat);
        n_total++; if (lat !== 18) $display("FAIL b2b_ld_latency: got %0d want 18", lat);
            else n_pass++;
        n_total++; if (rdata !== wd) $display("FAIL b2b_rdata: got %h want %h", rdata, wd);
            else n_pass++;
        n_total++; if (both_n !== 0) $display("FAIL both_strobes: got %0d want 0", both_n);
            else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_wrap();
        test_ignored();
        test_reset_mid_load();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
